soma_bcd_serial: RTL and testbench

Parametrised, digit-serial BCD adder for the calculator datapath, successor to the single-digit combinational adder. Accepts two packed multi-digit BCD operands on a start strobe, processes one decimal digit per clock (least significant first) with decimal carry propagation, and presents a registered multi-digit result with carry-out and a one-cycle completion pulse. Sits between the operand registers and the display/result register of the calculator.

---
 rtl/soma_bcd_serial.sv | 156 +++++++++++++++
 tb/tb_soma_bcd_serial.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/soma_bcd_serial.sv
// Digit-serial BCD adder: one decimal digit per clock, least significant first.
// Optional ten's-complement subtraction when SUBTRACAO_EN is defined (adds modo/negativo ports).
module soma_bcd_serial #(
    parameter int unsigned DIGITOS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   agora,
    input  logic [4*DIGITOS-1:0]   A,
    input  logic [4*DIGITOS-1:0]   B,
`ifdef SUBTRACAO_EN
    input  logic                   modo,
    output logic                   negativo,
`endif
    output logic [4*DIGITOS-1:0]   S,
    output logic                   vai_um,
    output logic                   erro,
    output logic                   ocupado,
    output logic                   pronto
);

    localparam int unsigned W  = 4 * DIGITOS;
    localparam int unsigned CW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int unsigned IW = CW + 2;

    localparam logic [1:0] OCIOSO  = 2'd0;
    localparam logic [1:0] SOMANDO = 2'd1;
    localparam logic [1:0] FIM     = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [W-1:0]  a_r, a_nxt, b_r, b_nxt, acc, acc_nxt, s_nxt;
    logic          modo_r, modo_nxt, carry, carry_nxt;
    logic          vai_um_nxt, erro_nxt, ocupado_nxt, pronto_nxt;
    logic          modo_in;

`ifdef SUBTRACAO_EN
    logic          negativo_nxt;
    assign modo_in = modo;
`else
    assign modo_in = 1'b0;
`endif

    // Current digit datapath
    logic [IW-1:0] base;
    logic [3:0]    a_dig, b_dig, b_eff, dig;
    logic [4:0]    t;
    logic          c_out, bad;
    logic [W-1:0]  acc_dig;

    always_comb begin
        base    = {cnt, 2'b00};
        a_dig   = a_r[base +: 4];
        b_dig   = b_r[base +: 4];
        b_eff   = modo_r ? 4'(4'd9 - b_dig) : b_dig;
        t       = 5'(a_dig) + 5'(b_eff) + 5'(carry);
        bad     = (a_dig > 4'd9) || (b_dig > 4'd9);
        if (t > 5'd9) begin
            dig   = 4'(t + 5'd6);
            c_out = 1'b1;
        end else begin
            dig   = t[3:0];
            c_out = 1'b0;
        end
        acc_dig             = acc;
        acc_dig[base +: 4]  = dig;
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        a_nxt      = a_r;
        b_nxt      = b_r;
        modo_nxt   = modo_r;
        carry_nxt  = carry;
        acc_nxt    = acc;
        s_nxt      = S;
        vai_um_nxt = vai_um;
        erro_nxt   = erro;
`ifdef SUBTRACAO_EN
        negativo_nxt = negativo;
`endif
        case (state)
            OCIOSO, FIM: begin
                if (agora) begin
                    state_nxt = SOMANDO;
                    cnt_nxt   = '0;
                    a_nxt     = A;
                    b_nxt     = B;
                    modo_nxt  = modo_in;
                    carry_nxt = modo_in;
                    acc_nxt   = '0;
                    erro_nxt  = 1'b0;
                end else begin
                    state_nxt = OCIOSO;
                end
            end
            SOMANDO: begin
                acc_nxt   = acc_dig;
                carry_nxt = c_out;
                erro_nxt  = erro | bad;
                cnt_nxt   = cnt + CW'(1);
                if (cnt == CW'(DIGITOS - 1)) begin
                    state_nxt  = FIM;
                    cnt_nxt    = '0;
                    s_nxt      = acc_dig;
                    vai_um_nxt = c_out;
`ifdef SUBTRACAO_EN
                    negativo_nxt = modo_r & ~c_out;
`endif
                end
            end
            default: state_nxt = OCIOSO;
        endcase
        ocupado_nxt = (state_nxt == SOMANDO);
        pronto_nxt  = (state_nxt == FIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OCIOSO;
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            modo_r  <= 1'b0;
            carry   <= 1'b0;
            acc     <= '0;
            S       <= '0;
            vai_um  <= 1'b0;
            erro    <= 1'b0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
`ifdef SUBTRACAO_EN
            negativo <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            a_r     <= a_nxt;
            b_r     <= b_nxt;
            modo_r  <= modo_nxt;
            carry   <= carry_nxt;
            acc     <= acc_nxt;
            S       <= s_nxt;
            vai_um  <= vai_um_nxt;
            erro    <= erro_nxt;
            ocupado <= ocupado_nxt;
            pronto  <= pronto_nxt;
`ifdef SUBTRACAO_EN
            negativo <= negativo_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_soma_bcd_serial.sv
// Bench for soma_bcd_serial: directed operations plus random traffic, checked every cycle
// against a transaction-level model of the adder.
module tb_soma_bcd_serial;

    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         agora = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         modo = 1'b0;
    logic [W-1:0] S;
    logic         vai_um, erro, ocupado, pronto;
`ifdef SUBTRACAO_EN
    logic         negativo;
`endif

    int errors = 0;
    int checks = 0;
    bit en_cmp = 1'b0;

    soma_bcd_serial #(.DIGITOS(D)) dut (
        .clk(clk), .rst(rst), .agora(agora), .A(A), .B(B),
`ifdef SUBTRACAO_EN
        .modo(modo), .negativo(negativo),
`endif
        .S(S), .vai_um(vai_um), .erro(erro), .ocupado(ocupado), .pronto(pronto)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Digit rule applied over the whole word
    function automatic void compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                    output logic [W-1:0] s, output logic c);
        int ai, bi, t;
        c = m;
        s = '0;
        for (int d = 0; d < D; d++) begin
            ai = int'((a >> (4 * d)) & 16'hF);
            bi = int'((b >> (4 * d)) & 16'hF);
            if (m) bi = (9 - bi) & 15;
            t = ai + bi + int'(c);
            if (t > 9) begin
                s = s | (W'((t + 6) & 15) << (4 * d));
                c = 1'b1;
            end else begin
                s = s | (W'(t) << (4 * d));
                c = 1'b0;
            end
        end
    endfunction

    function automatic longint to_int(input logic [W-1:0] v);
        longint r = 0;
        for (int d = D - 1; d >= 0; d--) r = r * 10 + longint'((v >> (4 * d)) & 16'hF);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r = '0;
        for (int d = 0; d < D; d++) begin
            r = r | (W'(v % 10) << (4 * d));
            v = v / 10;
        end
        return r;
    endfunction

    function automatic bit any_bad(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        return (((a >> (4 * k)) & 16'hF) > 9) || (((b >> (4 * k)) & 16'hF) > 9);
    endfunction

    // Transaction timeline model: an accepted op spends D cycles busy, then one cycle done
    bit           m_act = 0, m_m = 0, m_c = 0, m_neg = 0, m_err = 0, m_busy = 0, m_pronto = 0;
    int           m_k = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_S = '0;

    always @(posedge clk or posedge rst) begin
        logic [W-1:0] s;
        logic         c;
        if (rst) begin
            m_act = 0; m_m = 0; m_c = 0; m_neg = 0; m_err = 0; m_busy = 0; m_pronto = 0;
            m_k = 0; m_S = '0;
        end else if (m_act) begin
            if (any_bad(m_a, m_b, m_k)) m_err = 1;
            m_k++;
            if (m_k == D) begin
                compute(m_a, m_b, m_m, s, c);
                m_S = s; m_c = c; m_neg = m_m & ~c;
                m_act = 0; m_busy = 0; m_pronto = 1;
            end
        end else begin
            m_pronto = 0;
            if (agora) begin
                m_a = A; m_b = B; m_m = modo;
                m_act = 1; m_k = 0; m_err = 0; m_busy = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (en_cmp && !rst) begin
            chk("S", 64'(S), 64'(m_S));
            chk("vai_um", 64'(vai_um), 64'(m_c));
            chk("erro", 64'(erro), 64'(m_err));
            chk("ocupado", 64'(ocupado), 64'(m_busy));
            chk("pronto", 64'(pronto), 64'(m_pronto));
`ifdef SUBTRACAO_EN
            chk("negativo", 64'(negativo), 64'(m_neg));
`endif
        end
    end

    task automatic op_begin(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        @(posedge clk); #1;
        A = a; B = b; modo = m; agora = 1'b1;
        @(posedge clk); #1;
        agora = 1'b0;
    endtask

    task automatic wait_pronto(output int n);
        n = 0;
        while (!pronto && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r = '0;
        for (int d = 0; d < D; d++) begin
            if ($urandom_range(19) == 0) r = r | (W'($urandom_range(15, 10)) << (4 * d));
            else r = r | (W'($urandom_range(9)) << (4 * d));
        end
        return r;
    endfunction

    initial begin
        int n;
        logic [W-1:0] s, a, b;
        logic c;
        longint ai, bi, p;

        // Pin the model against hand-computed values and plain integer arithmetic
        compute(16'h1234, 16'h5678, 1'b0, s, c);
        chk("model_1234+5678", {47'd0, c, s}, {47'd0, 1'b0, 16'h6912});
        compute(16'h9999, 16'h0001, 1'b0, s, c);
        chk("model_9999+0001", {47'd0, c, s}, {47'd0, 1'b1, 16'h0000});
        compute(16'h0123, 16'h0500, 1'b1, s, c);
        chk("model_0123-0500", {47'd0, c, s}, {47'd0, 1'b0, 16'h9623});
        p = 10000;
        for (int i = 0; i < 40; i++) begin
            ai = longint'($urandom_range(9999));
            bi = longint'($urandom_range(9999));
            a = to_bcd(ai); b = to_bcd(bi);
            compute(a, b, 1'b0, s, c);
            chk("model_add_int", {47'd0, c, s}, {47'd0, 1'(ai + bi >= p), to_bcd((ai + bi) % p)});
            compute(a, b, 1'b1, s, c);
            chk("model_sub_int", {47'd0, c, s}, {47'd0, 1'(ai >= bi), to_bcd((ai - bi + p) % p)});
            chk("model_conv", 64'(to_int(a)), 64'(ai));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_flags", {60'd0, vai_um, erro, ocupado, pronto}, 64'd0);
        rst = 1'b0;
        en_cmp = 1'b1;

        op_begin(16'h1234, 16'h5678, 1'b0);
        wait_pronto(n);
        chk("latency", 64'(n), 64'(D));
        chk("add_S", 64'(S), 64'h6912);
        chk("add_c_err", {62'd0, vai_um, erro}, 64'd0);

        // Back-to-back acceptance during the completion cycle
        op_begin(16'h9999, 16'h0001, 1'b0);
        wait_pronto(n);
        chk("wrap_S", 64'(S), 64'h0000);
        chk("wrap_c", 64'(vai_um), 64'd1);
        A = 16'h0A00; B = 16'h0000; agora = 1'b1;
        @(posedge clk); #1;
        agora = 1'b0;
        wait_pronto(n);
        chk("b2b_gap", 64'(n + 1), 64'(D + 1));
        chk("erro_set", 64'(erro), 64'd1);

        op_begin(16'h0001, 16'h0001, 1'b0);
        wait_pronto(n);
        chk("erro_clr", 64'(erro), 64'd0);
        chk("one_S", 64'(S), 64'h0002);

        // agora during the busy phase must be ignored
        op_begin(16'h2222, 16'h3333, 1'b0);
        @(posedge clk); #1;
        A = 16'h7777; B = 16'h1111; agora = 1'b1;
        @(posedge clk); #1;
        agora = 1'b0;
        wait_pronto(n);
        chk("ign_S", 64'(S), 64'h5555);
        chk("ign_latency", 64'(n + 2), 64'(D));

        // Asynchronous reset mid-operation
        op_begin(16'h4444, 16'h4444, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_S", 64'(S), 64'd0);
        chk("arst_flags", {60'd0, vai_um, erro, ocupado, pronto}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        repeat (D + 2) begin
            @(posedge clk); #1;
            if (pronto) n++;
        end
        chk("arst_no_pronto", 64'(n), 64'd0);
        op_begin(16'h0005, 16'h0005, 1'b0);
        wait_pronto(n);
        chk("post_rst_S", 64'(S), 64'h0010);

`ifdef SUBTRACAO_EN
        op_begin(16'h0500, 16'h0123, 1'b1);
        wait_pronto(n);
        chk("sub_pos", {46'd0, negativo, vai_um, S}, {46'd0, 1'b0, 1'b1, 16'h0377});
        op_begin(16'h0123, 16'h0500, 1'b1);
        wait_pronto(n);
        chk("sub_neg", {46'd0, negativo, vai_um, S}, {46'd0, 1'b1, 1'b0, 16'h9623});
`endif

        // Random traffic; the per-cycle compare does the checking
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            agora = ($urandom_range(2) == 0);
            A = rand_bcd();
            B = rand_bcd();
`ifdef SUBTRACAO_EN
            modo = 1'($urandom_range(1));
`endif
        end
        agora = 1'b0;
        repeat (D + 3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
